// File: rtl/spi_flash_pkg.sv
// Shared constants and FSM state type for the SPI NOR flash read controller.
// SPI_FLASH_FAST_READ_EN selects FAST_READ (0x0B) with 8 dummy clocks instead of READ (0x03).
package spi_flash_pkg;

    localparam logic [7:0] SPI_OP_READ      = 8'h03;
    localparam logic [7:0] SPI_OP_FAST_READ = 8'h0B;

    localparam int unsigned CMD_BITS   = 8;
    localparam int unsigned ADDR_BITS  = 24;
    localparam int unsigned DUMMY_BITS = 8;
    localparam int unsigned DATA_BITS  = 32;
    localparam int unsigned BIT_CNT_W  = 7;

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] SPI_OP = SPI_OP_FAST_READ;
`else
    localparam logic [7:0] SPI_OP = SPI_OP_READ;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
`ifdef SPI_FLASH_FAST_READ_EN
        ST_DUMMY,
`endif
        ST_DATA,
        ST_GAP
    } spi_state_e;

    // Bytes arrive first-byte-in-MSB; the bus wants byte 0 in the low lane.
    function automatic logic [31:0] le_word(input logic [31:0] rx);
        return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
    endfunction

endpackage

// File: rtl/spi_flash_rd_ctrl_spi_clk_div.sv
// SPI mode-0 clock divider: spi_clk idles low, each bit period is low then high for CLK_DIV cycles.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic en_i,
    output logic spi_clk_o,
    output logic rise_pulse_c_o,
    output logic fall_pulse_c_o
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             clk_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
            clk_q <= ~clk_q;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // rise: first cycle with spi_clk high; fall: last cycle of the bit period.
    assign rise_pulse_c_o = en_i && clk_q && (cnt_q == '0);
    assign fall_pulse_c_o = en_i && clk_q && (cnt_q == CNT_MAX);
    assign spi_clk_o      = clk_q;

endmodule

// File: rtl/spi_flash_rd_ctrl.sv
// Memory-mapped SPI NOR flash word reader: one mode-0 READ per request, little-endian 32-bit result.
// Build macro SPI_FLASH_FAST_READ_EN switches to FAST_READ with a dummy phase.
module spi_flash_rd_ctrl
    import spi_flash_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned CS_HIGH_CYC = 4
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        spi_clk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int unsigned GAP_W = $clog2(CS_HIGH_CYC) + 1;

    spi_state_e           state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [31:0]          tx_q, tx_d;
    logic [31:0]          rx_q, rx_d;
    logic [31:0]          rsp_data_q, rsp_data_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 cs_n_q, cs_n_d;
    logic                 req_ready_q, req_ready_d;
    logic                 rise_c, fall_c;
    logic                 addr_lsb_unused;

    assign addr_lsb_unused = ^req_addr[1:0];

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk_i          (sys_clk),
        .rst_n          (rst_n),
        .en_i           (!cs_n_q),
        .spi_clk_o      (spi_clk),
        .rise_pulse_c_o (rise_c),
        .fall_pulse_c_o (fall_c)
    );

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        cs_n_d      = cs_n_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d   = ST_CMD;
                    cs_n_d    = 1'b0;
                    tx_d      = {SPI_OP, req_addr[23:2], 2'b00};
                    bit_cnt_d = BIT_CNT_W'(CMD_BITS - 1);
                end
            end
            ST_CMD: begin
                if (fall_c) begin
                    tx_d = tx_q << 1;
                    if (bit_cnt_q == '0) begin
                        state_d   = ST_ADDR;
                        bit_cnt_d = BIT_CNT_W'(ADDR_BITS - 1);
                    end else begin
                        bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
                    end
                end
            end
            // Zero fill on shift leaves mosi low for the dummy and data phases.
            ST_ADDR: begin
                if (fall_c) begin
                    tx_d = tx_q << 1;
                    if (bit_cnt_q == '0) begin
`ifdef SPI_FLASH_FAST_READ_EN
                        state_d   = ST_DUMMY;
                        bit_cnt_d = BIT_CNT_W'(DUMMY_BITS - 1);
`else
                        state_d   = ST_DATA;
                        bit_cnt_d = BIT_CNT_W'(DATA_BITS - 1);
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
                    end
                end
            end
`ifdef SPI_FLASH_FAST_READ_EN
            ST_DUMMY: begin
                if (fall_c) begin
                    if (bit_cnt_q == '0) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = BIT_CNT_W'(DATA_BITS - 1);
                    end else begin
                        bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
                    end
                end
            end
`endif
            ST_DATA: begin
                if (rise_c) begin
                    rx_d = {rx_q[30:0], spi_miso};
                end
                if (fall_c) begin
                    if (bit_cnt_q == '0) begin
                        state_d     = ST_GAP;
                        cs_n_d      = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = le_word(rx_d);
                        gap_cnt_d   = GAP_W'(CS_HIGH_CYC - 1);
                    end else begin
                        bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            cs_n_q      <= 1'b1;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            cs_n_q      <= cs_n_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_mosi  = tx_q[31];

endmodule

// File: tb/tb_spi_flash_rd_ctrl.sv
// Bench for spi_flash_rd_ctrl: two instances (CLK_DIV=2 and CLK_DIV=1) against a byte-array flash model.
module tb_spi_flash_rd_ctrl;

    localparam int unsigned CS_HIGH_CYC = 4;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam int PRE = 40;
    localparam logic [7:0] EXP_OP = 8'h0B;
`else
    localparam int PRE = 32;
    localparam logic [7:0] EXP_OP = 8'h03;
`endif
    localparam int NBITS = PRE + 32;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [23:0] req_addr  [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_data  [2];
    logic        spi_clk   [2];
    logic        spi_cs_n  [2];
    logic        spi_mosi  [2];
    logic        spi_miso  [2];

    logic [7:0]  mem [1024];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          last_rsp [2];

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        spi_flash_rd_ctrl #(
            .CLK_DIV     (g == 0 ? 2 : 1),
            .CS_HIGH_CYC (CS_HIGH_CYC)
        ) u_dut (
            .sys_clk   (sys_clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_addr  (req_addr[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_data  (rsp_data[g]),
            .spi_clk   (spi_clk[g]),
            .spi_cs_n  (spi_cs_n[g]),
            .spi_mosi  (spi_mosi[g]),
            .spi_miso  (spi_miso[g])
        );
    end

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [23:0] addr);
        logic [23:0] a;
        a = {addr[23:2], 2'b00};
        return {mem[10'(a + 3)], mem[10'(a + 2)], mem[10'(a + 1)], mem[a[9:0]]};
    endfunction

    // Issue one read on instance g, act as the flash, and check the whole transaction.
    // abort_at > 0 pulls rst_n low once that many spi_clk rises have been seen.
    task automatic do_read(input int g, input logic [23:0] addr, input int abort_at);
        int d, n, t_acc, k, rise_n, j;
        logic prev_clk, prev_cs, busy_ready;
        logic [39:0] pre_sr;
        logic [23:0] cap;
        logic [7:0]  b;
        bit done, aborted;
        d = (g == 0) ? 2 : 1;
        req_addr[g]  = addr;
        req_valid[g] = 1'b1;
        n = 0;
        while (req_ready[g] !== 1'b1 && n < 200) begin
            chk("idle_rsp", 40'(rsp_valid[g]), 40'd0);
            @(negedge sys_clk);
            n++;
        end
        chk("ready_timeout", 40'(n < 200), 40'd1);
        if (last_rsp[g] >= 0)
            chk("gap_cycles", 40'((cyc - last_rsp[g]) >= CS_HIGH_CYC), 40'd1);
        t_acc = cyc;
        @(negedge sys_clk);
        req_valid[g] = 1'b0;
        chk("cs_low_T1", 40'(spi_cs_n[g]), 40'd0);
        rise_n = 0; prev_clk = 1'b0; prev_cs = 1'b1; pre_sr = '0; cap = '0;
        done = 0; aborted = 0; busy_ready = 1'b0; k = 1;
        while (!done && k < NBITS * 2 * d + 40) begin
            if (rsp_valid[g] === 1'b1) begin
                chk("latency", 40'(k), 40'(1 + NBITS * 2 * d));
                chk("cs_rise_at_rsp", 40'(spi_cs_n[g]), 40'd1);
                chk("clk_idle_at_rsp", 40'(spi_clk[g]), 40'd0);
                chk("rsp_data", 40'(rsp_data[g]), 40'(exp_word(addr)));
                last_rsp[g] = cyc;
                done = 1;
            end else begin
                if (req_ready[g] === 1'b1) busy_ready = 1'b1;
                if (!spi_cs_n[g] && spi_clk[g] && !prev_clk) begin
                    if (rise_n < PRE) pre_sr = {pre_sr[38:0], spi_mosi[g]};
                    rise_n++;
                    if (rise_n == PRE) cap = (PRE == 40) ? pre_sr[31:8] : pre_sr[23:0];
                    if (rise_n == abort_at) begin
                        rst_n = 1'b0;
                        #1;
                        chk("rst_cs_n", 40'(spi_cs_n[g]), 40'd1);
                        chk("rst_spi_clk", 40'(spi_clk[g]), 40'd0);
                        chk("rst_rsp_valid", 40'(rsp_valid[g]), 40'd0);
                        chk("rst_mosi", 40'(spi_mosi[g]), 40'd0);
                        aborted = 1;
                        done = 1;
                    end
                end
                if (!aborted && !spi_cs_n[g] && !spi_clk[g] && (prev_clk || prev_cs)) begin
                    j = rise_n - PRE;
                    if (j >= 0 && j < 32) begin
                        b = mem[10'(cap + 24'(j / 8))];
                        spi_miso[g] = b[7 - (j % 8)];
                    end
                end
                prev_clk = spi_clk[g];
                prev_cs  = spi_cs_n[g];
                if (!aborted) begin
                    @(negedge sys_clk);
                    k++;
                end
            end
        end
        if (!aborted) begin
            chk("rsp_timeout", 40'(done), 40'd1);
            chk("ready_while_busy", 40'(busy_ready), 40'd0);
            chk("rise_count", 40'(rise_n), 40'(NBITS));
            chk("opcode", 40'((PRE == 40) ? pre_sr[39:32] : pre_sr[31:24]), 40'(EXP_OP));
            chk("mosi_addr", 40'(cap), 40'({addr[23:2], 2'b00}));
            if (PRE == 40) chk("dummy_mosi", 40'(pre_sr[7:0]), 40'd0);
            @(negedge sys_clk);
            chk("rsp_pulse", 40'(rsp_valid[g]), 40'd0);
            chk("rsp_hold", 40'(rsp_data[g]), 40'(exp_word(addr)));
        end
    endtask

    initial begin
        logic stray;
        int g;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_addr[i]  = '0;
            spi_miso[i]  = 1'b0;
            last_rsp[i]  = -1;
        end
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
        mem[10'h104] = 8'hEF; mem[10'h105] = 8'hBE; mem[10'h106] = 8'hAD; mem[10'h107] = 8'hDE;

        repeat (3) @(negedge sys_clk);
        chk("rst_req_ready", 40'(req_ready[0]), 40'd0);
        chk("rst_rsp_valid", 40'(rsp_valid[0]), 40'd0);
        chk("rst_rsp_data", 40'(rsp_data[0]), 40'd0);
        chk("rst_spi_clk", 40'(spi_clk[0]), 40'd0);
        chk("rst_cs_n", 40'(spi_cs_n[0]), 40'd1);
        chk("rst_mosi", 40'(spi_mosi[0]), 40'd0);
        chk("rst_cs_n_div1", 40'(spi_cs_n[1]), 40'd1);
        rst_n = 1'b1;
        @(negedge sys_clk);
        chk("ready_after_rst", 40'(req_ready[0]), 40'd1);
        chk("ready_after_rst_div1", 40'(req_ready[1]), 40'd1);

        do_read(0, 24'h000000, 0);
        chk("word_0x13", 40'(rsp_data[0]), 40'h13);
        do_read(0, 24'h000106, 0);
        chk("word_deadbeef", 40'(rsp_data[0]), 40'hDEADBEEF);
        do_read(0, 24'($urandom), 0);

        // Abort mid-address; no response may follow and the next read must work.
        do_read(0, 24'($urandom), 12);
        for (int i = 0; i < 2; i++) last_rsp[i] = -1;
        repeat (2) @(negedge sys_clk);
        chk("ready_in_rst", 40'(req_ready[0]), 40'd0);
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (300) begin
            @(negedge sys_clk);
            if (rsp_valid[0] === 1'b1) stray = 1'b1;
        end
        chk("no_rsp_after_abort", 40'(stray), 40'd0);
        chk("rsp_data_cleared", 40'(rsp_data[0]), 40'd0);
        do_read(0, 24'h000106, 0);

        do_read(1, 24'h000000, 0);
        chk("div1_word_0x13", 40'(rsp_data[1]), 40'h13);
        do_read(1, 24'h000106, 0);

        for (int i = 0; i < 12; i++) begin
            g = int'($urandom_range(0, 1));
            repeat ($urandom_range(0, 6)) @(negedge sys_clk);
            do_read(g, 24'($urandom), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
